// File: rtl/freq_measure_ctrl.sv
// Measures high time, low time and period of an asynchronous input, optionally averaged over 2^AVG_LOG2 periods.
// Averaging is compiled in only when the macro FREQ_MEASURE_AVG_EN is defined.
module freq_measure_ctrl #(
    parameter int CNT_W       = 20,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             IN,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             timeout_err,
    output logic [CNT_W-1:0] on_count,
    output logic [CNT_W-1:0] off_count,
    output logic [CNT_W-1:0] period
);

`ifdef FREQ_MEASURE_AVG_EN
    localparam int AVG = AVG_LOG2;
`else
    // Single-period build: the parameter is kept only so both builds share one interface.
    localparam int AVG = 0 * AVG_LOG2;
`endif

    localparam int ACC_W = CNT_W + AVG;
    localparam int IDX_W = AVG + 1;
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] NPER = IDX_W'(2 ** AVG);
    localparam logic [TW-1:0]    TMO  = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, DONE, ERR} state_t;

    state_t             state;
    logic               s1, ins, ins_d;
    logic               rise, fall;
    logic [CNT_W-1:0]   hi_cnt, lo_cnt, hi_inc, lo_inc;
    logic [ACC_W-1:0]   acc_hi, acc_lo, sum_hi, sum_lo;
    logic [CNT_W-1:0]   avg_hi, avg_lo, per_sat;
    logic [CNT_W:0]     per_sum;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [TW-1:0]      timer, timer_nx;
    logic               to_err;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1    <= 1'b0;
            ins   <= 1'b0;
            ins_d <= 1'b0;
        end else begin
            s1    <= IN;
            ins   <= s1;
            ins_d <= ins;
        end
    end

    assign rise = ins & ~ins_d;
    assign fall = ~ins & ins_d;

    assign hi_inc   = (hi_cnt == '1) ? hi_cnt : hi_cnt + 1'b1;
    assign lo_inc   = (lo_cnt == '1) ? lo_cnt : lo_cnt + 1'b1;
    assign timer_nx = timer + 1'b1;
    assign idx_nx   = idx + 1'b1;

    // Sums include the period being closed this cycle so the result is ready on the DONE edge.
    assign sum_hi  = acc_hi + ACC_W'(hi_cnt);
    assign sum_lo  = acc_lo + ACC_W'(lo_cnt);
    assign avg_hi  = sum_hi[ACC_W-1:AVG];
    assign avg_lo  = sum_lo[ACC_W-1:AVG];
    assign per_sum = {1'b0, avg_hi} + {1'b0, avg_lo};
    assign per_sat = per_sum[CNT_W] ? '1 : per_sum[CNT_W-1:0];

    assign to_err = (timer_nx == TMO) &&
                    (((state == ARM)  && !rise) ||
                     ((state == HIGH) && !fall) ||
                     ((state == LOW)  && !rise));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            valid       <= 1'b0;
            timeout_err <= 1'b0;
            on_count    <= '0;
            off_count   <= '0;
            period      <= '0;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            idx         <= '0;
            timer       <= '0;
        end else begin
            done <= 1'b0;
            if ((state != IDLE) && abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (to_err) begin
                state       <= ERR;
                done        <= 1'b1;
                timeout_err <= 1'b1;
                valid       <= 1'b0;
                on_count    <= '0;
                off_count   <= '0;
                period      <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= ARM;
                            busy        <= 1'b1;
                            valid       <= 1'b0;
                            timeout_err <= 1'b0;
                            hi_cnt      <= '0;
                            lo_cnt      <= '0;
                            acc_hi      <= '0;
                            acc_lo      <= '0;
                            idx         <= '0;
                            timer       <= '0;
                        end
                    end
                    ARM: begin
                        if (rise) begin
                            state  <= HIGH;
                            hi_cnt <= CNT_W'(1);
                            timer  <= TW'(1);
                        end else begin
                            timer <= timer_nx;
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            state  <= LOW;
                            lo_cnt <= CNT_W'(1);
                            timer  <= TW'(1);
                        end else begin
                            hi_cnt <= hi_inc;
                            timer  <= timer_nx;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            acc_hi <= sum_hi;
                            acc_lo <= sum_lo;
                            idx    <= idx_nx;
                            if (idx_nx == NPER) begin
                                state     <= DONE;
                                done      <= 1'b1;
                                valid     <= 1'b1;
                                on_count  <= avg_hi;
                                off_count <= avg_lo;
                                period    <= per_sat;
                            end else begin
                                // The closing edge is also the first high cycle of the next period.
                                state  <= HIGH;
                                hi_cnt <= CNT_W'(1);
                                lo_cnt <= '0;
                                timer  <= TW'(1);
                            end
                        end else begin
                            lo_cnt <= lo_inc;
                            timer  <= timer_nx;
                        end
                    end
                    DONE, ERR: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Directed self-checking bench for freq_measure_ctrl; expected values follow the build's FREQ_MEASURE_AVG_EN setting.
module tb_freq_measure_ctrl;

    localparam int CNT_W = 20;

`ifdef FREQ_MEASURE_AVG_EN
    localparam int AVG_ON = 5, AVG_OFF = 4, AVG_PER = 9;
`else
    localparam int AVG_ON = 4, AVG_OFF = 4, AVG_PER = 8;
`endif

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             in_sig = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             busy, done, valid, timeout_err;
    logic [CNT_W-1:0] on_count, off_count, period;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int done_cnt = 0;
    bit wave_on = 1'b0;
    int hi_len[4];
    int lo_len = 3;

    freq_measure_ctrl #(.CNT_W(CNT_W), .AVG_LOG2(2), .TIMEOUT_CYC(100)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN(in_sig), .start(start), .abort(abort),
        .busy(busy), .done(done), .valid(valid), .timeout_err(timeout_err),
        .on_count(on_count), .off_count(off_count), .period(period)
    );

    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc = cyc + 1;
    end

    initial forever begin
        @(posedge CLK);
        #1;
        if (done) done_cnt = done_cnt + 1;
    end

    // Square-wave generator cycling through hi_len[0..3], each followed by lo_len low cycles.
    initial begin
        int gcnt, gidx;
        bit nxt;
        gcnt = 0;
        gidx = 0;
        forever begin
            @(negedge CLK);
            if (!wave_on) begin
                in_sig = 1'b0;
                gcnt = 0;
                gidx = 0;
            end else begin
                nxt = (gcnt < hi_len[gidx]);
                if (nxt && !in_sig) rise_cyc = cyc;
                in_sig = nxt;
                gcnt++;
                if (gcnt == hi_len[gidx] + lo_len) begin
                    gcnt = 0;
                    gidx = (gidx + 1) % 4;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic set_wave(input int h0, input int h1, input int h2, input int h3, input int lo);
        hi_len[0] = h0; hi_len[1] = h1; hi_len[2] = h2; hi_len[3] = h3;
        lo_len = lo;
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit got, output int n);
        got = 1'b0;
        n = 0;
        while (!got && n < max) begin
            @(negedge CLK);
            n++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge CLK);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_tmo got=%b exp=0", timeout_err); end
        checks++; if (on_count !== '0) begin failures++; $display("[TB] FAIL reset_on got=%0d exp=0", on_count); end
        checks++; if (off_count !== '0) begin failures++; $display("[TB] FAIL reset_off got=%0d exp=0", off_count); end
        checks++; if (period !== '0) begin failures++; $display("[TB] FAIL reset_period got=%0d exp=0", period); end
        RST_N = 1'b1;
        idle(3);
    endtask

    task automatic test_basic();
        bit got;
        int n, d0;
        d0 = done_cnt;
        set_wave(5, 5, 5, 5, 3);
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_busy_rise got=%b exp=1", busy); end
        wave_on = 1'b1;
        wait_done(200, got, n);
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL basic_done_seen got=%b exp=1", got); end
        checks++; if (on_count !== 5) begin failures++; $display("[TB] FAIL basic_on got=%0d exp=5", on_count); end
        checks++; if (off_count !== 3) begin failures++; $display("[TB] FAIL basic_off got=%0d exp=3", off_count); end
        checks++; if (period !== 8) begin failures++; $display("[TB] FAIL basic_period got=%0d exp=8", period); end
        checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid got=%b exp=1", valid); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL basic_tmo got=%b exp=0", timeout_err); end
        checks++; if (cyc - rise_cyc !== 3) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=3", cyc - rise_cyc); end
        wave_on = 1'b0;
        idle(4);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy_fall got=%b exp=0", busy); end
        checks++; if (valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid_hold got=%b exp=1", valid); end
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("[TB] FAIL basic_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_average();
        bit got;
        int n;
        set_wave(4, 5, 6, 7, 4);
        pulse_start();
        wave_on = 1'b1;
        wait_done(300, got, n);
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL avg_done_seen got=%b exp=1", got); end
        checks++; if (on_count !== AVG_ON) begin failures++; $display("[TB] FAIL avg_on got=%0d exp=%0d", on_count, AVG_ON); end
        checks++; if (off_count !== AVG_OFF) begin failures++; $display("[TB] FAIL avg_off got=%0d exp=%0d", off_count, AVG_OFF); end
        checks++; if (period !== AVG_PER) begin failures++; $display("[TB] FAIL avg_period got=%0d exp=%0d", period, AVG_PER); end
        wave_on = 1'b0;
        idle(4);
    endtask

    task automatic test_abort();
        bit got;
        int n, d0;
        d0 = done_cnt;
        set_wave(5, 5, 5, 5, 3);
        pulse_start();
        wave_on = 1'b1;
        idle(5);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (on_count !== AVG_ON) begin failures++; $display("[TB] FAIL abort_on_kept got=%0d exp=%0d", on_count, AVG_ON); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_valid got=%b exp=0", valid); end
        idle(30);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("[TB] FAIL abort_no_done got=%0d exp=0", done_cnt - d0); end
        wave_on = 1'b0;
        idle(4);
        pulse_start();
        wave_on = 1'b1;
        wait_done(200, got, n);
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL abort_rerun_done got=%b exp=1", got); end
        checks++; if (on_count !== 5) begin failures++; $display("[TB] FAIL abort_rerun_on got=%0d exp=5", on_count); end
        checks++; if (off_count !== 3) begin failures++; $display("[TB] FAIL abort_rerun_off got=%0d exp=3", off_count); end
        wave_on = 1'b0;
        idle(4);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("[TB] FAIL abort_done_count got=%0d exp=1", done_cnt - d0); end
    endtask

    task automatic test_reset_mid();
        bit got;
        int n, d0;
        set_wave(2, 2, 2, 2, 2);
        pulse_start();
        wave_on = 1'b1;
        idle(6);
        RST_N = 1'b0;
        wave_on = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid got=%b exp=0", valid); end
        checks++; if (on_count !== '0) begin failures++; $display("[TB] FAIL rstmid_on got=%0d exp=0", on_count); end
        checks++; if (off_count !== '0) begin failures++; $display("[TB] FAIL rstmid_off got=%0d exp=0", off_count); end
        checks++; if (period !== '0) begin failures++; $display("[TB] FAIL rstmid_period got=%0d exp=0", period); end
        idle(3);
        RST_N = 1'b1;
        d0 = done_cnt;
        idle(10);
        checks++; if (done_cnt - d0 !== 0) begin failures++; $display("[TB] FAIL rstmid_no_done got=%0d exp=0", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_idle got=%b exp=0", busy); end
        pulse_start();
        wave_on = 1'b1;
        wait_done(200, got, n);
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_done got=%b exp=1", got); end
        checks++; if (on_count !== 2) begin failures++; $display("[TB] FAIL rstmid_res_on got=%0d exp=2", on_count); end
        checks++; if (off_count !== 2) begin failures++; $display("[TB] FAIL rstmid_res_off got=%0d exp=2", off_count); end
        checks++; if (period !== 4) begin failures++; $display("[TB] FAIL rstmid_res_period got=%0d exp=4", period); end
        wave_on = 1'b0;
        idle(4);
    endtask

    task automatic test_back_to_back();
        bit got;
        int n, d0;
        d0 = done_cnt;
        set_wave(5, 5, 5, 5, 3);
        pulse_start();
        wave_on = 1'b1;
        idle(2);
        pulse_start();
        pulse_start();
        wait_done(200, got, n);
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL b2b_done got=%b exp=1", got); end
        checks++; if (on_count !== 5) begin failures++; $display("[TB] FAIL b2b_on got=%0d exp=5", on_count); end
        idle(20);
        checks++; if (done_cnt - d0 !== 1) begin failures++; $display("[TB] FAIL b2b_single_done got=%0d exp=1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle got=%b exp=0", busy); end
        wave_on = 1'b0;
        idle(4);
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy_rise got=%b exp=1", busy); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_valid_clear got=%b exp=0", valid); end
        wave_on = 1'b1;
        wait_done(200, got, n);
        checks++; if (off_count !== 3) begin failures++; $display("[TB] FAIL b2b_second_off got=%0d exp=3", off_count); end
        wave_on = 1'b0;
        idle(4);
        checks++; if (done_cnt - d0 !== 2) begin failures++; $display("[TB] FAIL b2b_done_total got=%0d exp=2", done_cnt - d0); end
    endtask

    task automatic test_timeout();
        bit got;
        int n;
        wave_on = 1'b0;
        idle(4);
        pulse_start();
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("[TB] FAIL tmo_clear_on_start got=%b exp=0", timeout_err); end
        wait_done(300, got, n);
        checks++; if (got !== 1'b1) begin failures++; $display("[TB] FAIL tmo_done got=%b exp=1", got); end
        checks++; if (n < 98 || n > 102) begin failures++; $display("[TB] FAIL tmo_cycles got=%0d exp=98..102", n); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("[TB] FAIL tmo_flag got=%b exp=1", timeout_err); end
        checks++; if (valid !== 1'b0) begin failures++; $display("[TB] FAIL tmo_valid got=%b exp=0", valid); end
        checks++; if (on_count !== '0 || off_count !== '0 || period !== '0) begin
            failures++; $display("[TB] FAIL tmo_counts got=%0d/%0d/%0d exp=0/0/0", on_count, off_count, period);
        end
        idle(3);
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL tmo_idle got=%b exp=0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_average();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_measure_ctrl.md
FREQ_MEASURE_CTRL -- requirements
Module: freq_measure_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 20: width of every count output.
REQ-002 SHALL have parameter AVG_LOG2, default 2: log2 of periods averaged per measurement.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000: max cycles in any one phase before error.
REQ-004 SHALL have port CLK  input  1: sole clock, all state on rising edge.
REQ-005 SHALL have port RST_N  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port IN  input  1: asynchronous signal under measurement.
REQ-007 SHALL have port start  input  1: one-cycle measurement request.
REQ-008 SHALL have port abort  input  1: cancel the measurement in progress.
REQ-009 SHALL have port busy  output  1: high in any state except IDLE.
REQ-010 SHALL have port done  output  1: one-cycle completion pulse.
REQ-011 SHALL have port valid  output  1: result registers hold a good measurement.
REQ-012 SHALL have port timeout_err  output  1: last measurement ended in timeout.
REQ-013 SHALL have port on_count  output  CNT_W: high-phase cycles of IN.
REQ-014 SHALL have port off_count  output  CNT_W: low-phase cycles of IN.
REQ-015 SHALL have port period  output  CNT_W: on_count+off_count, saturating at 2^CNT_W-1.

Function
REQ-016 SHALL pass IN through a 2-flop synchronizer; all edge detection SHALL use the synchronized value (ins) and its one-cycle delayed copy.
REQ-017 SHALL implement states IDLE, ARM, HIGH, LOW, DONE, ERR.
REQ-018 IDLE: start=1 -> ARM, clear phase counters, accumulators and period index; start SHALL be ignored in every other state.
REQ-019 ARM: wait for ins rising edge -> HIGH; the edge cycle SHALL count as the first HIGH cycle.
REQ-020 HIGH: increment high counter each cycle ins=1; ins falling edge -> LOW, counting that cycle as the first LOW cycle.
REQ-021 LOW: increment low counter each cycle; ins rising edge ends the period: add both counters to accumulators, clear them, increment index; if index reaches 2^AVG_LOG2 -> DONE, else -> HIGH.
REQ-022 DONE: register on_count=acc_hi>>AVG_LOG2, off_count=acc_lo>>AVG_LOG2 (truncating), period=saturated sum; assert done and valid for this one cycle; -> IDLE next cycle; valid SHALL then stay high until the next accepted start or reset.
REQ-023 Accumulators SHALL be CNT_W+AVG_LOG2 wide and never overflow; phase counters SHALL saturate at 2^CNT_W-1.
REQ-024 Any phase counter (including ARM wait) reaching TIMEOUT_CYC -> ERR; ERR SHALL pulse done, set timeout_err=1, valid=0, zero the count outputs, -> IDLE.
REQ-025 abort=1 in any non-IDLE state -> IDLE next cycle, no done pulse, outputs unchanged; abort SHALL take priority over every other transition.
REQ-026 An accepted start SHALL clear valid and timeout_err in the same cycle busy rises.
REQ-027 Latency: done SHALL assert exactly one cycle after the synchronized rising edge that closes the final period.

Reset
REQ-028 RST_N low SHALL asynchronously force state IDLE, synchronizer flops 0, busy=0, done=0, valid=0, timeout_err=0, on_count=off_count=period=0.
REQ-029 Reset mid-measurement SHALL discard all partial accumulation; no done pulse on release.

Configuration
REQ-030 Macro FREQ_MEASURE_AVG_EN defined: averaging per REQ-021/022 with 2^AVG_LOG2 periods.
REQ-031 Macro FREQ_MEASURE_AVG_EN undefined: AVG_LOG2 SHALL be treated as 0, one period per measurement, no shift, accumulators CNT_W wide; all other behaviour identical.

Verification
REQ-032 IN square wave 5 high/3 low, start -> done once, valid=1, on_count=5, off_count=3, period=8, timeout_err=0.
REQ-033 AVG enabled, AVG_LOG2=2, high lengths 4,5,6,7 with low 4 -> on_count=5 (22>>2), off_count=4, period=9.
REQ-034 IN held 0, TIMEOUT_CYC=100, start -> done after ~100 cycles, timeout_err=1, valid=0, counts 0.
REQ-035 abort in HIGH, then start with 5/3 wave -> no done from first run; second run gives on_count=5, off_count=3.
REQ-036 RST_N low during LOW, release, start with 2/2 wave -> all outputs 0 during reset; result on_count=2, off_count=2, period=4.
REQ-037 start pulsed while busy -> ignored; exactly one done per accepted start.
